// File: rtl/dmem_responder.sv
// Data-memory responder: one word access outstanding, response LATENCY cycles after accept.
// Requests are refused outside IDLE; a response is held until resp_ready is seen.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic [3:0]        count;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              addr_err;
  logic              commit;

  assign idx      = addr_q[ADDR_W+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);
  assign commit   = (state == WAIT) && (count == 4'd0);

  assign req_ready  = (state == IDLE) && !reset;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            count   <= 4'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            resp_err   <= addr_err;
            resp_rdata <= (!we_q && !addr_err) ? mem[idx] : 32'd0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; commit is only reachable from WAIT, so a reset before the commit edge drops the store.
  always_ff @(posedge CLOCK_50) begin
    if (commit && we_q && !addr_err) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 4, 1) driven by directed steps,
// expected responses queued at issue and compared when each response appears.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  rst, req_v, req_r, req_w, rsp_v, rsp_r, rsp_e, bsy;
  logic [31:0] req_a [3];
  logic [31:0] req_d [3];
  logic [31:0] rsp_d [3];
  int lat [3] = '{2, 4, 1};

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t sb[$];

  dmem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) u0 (
    .CLOCK_50(clk), .reset(rst[0]), .req_valid(req_v[0]), .req_ready(req_r[0]),
    .req_we(req_w[0]), .req_addr(req_a[0]), .req_wdata(req_d[0]),
    .resp_valid(rsp_v[0]), .resp_ready(rsp_r[0]), .resp_rdata(rsp_d[0]),
    .resp_err(rsp_e[0]), .busy(bsy[0]));

  dmem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(4)) u1 (
    .CLOCK_50(clk), .reset(rst[1]), .req_valid(req_v[1]), .req_ready(req_r[1]),
    .req_we(req_w[1]), .req_addr(req_a[1]), .req_wdata(req_d[1]),
    .resp_valid(rsp_v[1]), .resp_ready(rsp_r[1]), .resp_rdata(rsp_d[1]),
    .resp_err(rsp_e[1]), .busy(bsy[1]));

  dmem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(1)) u2 (
    .CLOCK_50(clk), .reset(rst[2]), .req_valid(req_v[2]), .req_ready(req_r[2]),
    .req_we(req_w[2]), .req_addr(req_a[2]), .req_wdata(req_d[2]),
    .resp_valid(rsp_v[2]), .resp_ready(rsp_r[2]), .resp_rdata(rsp_d[2]),
    .resp_err(rsp_e[2]), .busy(bsy[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] rd, input logic err);
    exp_t e;
    e.rd  = rd;
    e.err = err;
    sb.push_back(e);
  endtask

  // Present a request and wait (bounded) for the accepting edge; acc is the cycle just after it.
  task automatic send(input int d, input logic w, input logic [31:0] a, input logic [31:0] data,
                      output int acc);
    int n = 0;
    req_v[d] = 1'b1;
    req_w[d] = w;
    req_a[d] = a;
    req_d[d] = data;
    while (!req_r[d] && n < 50) begin
      step();
      n++;
    end
    check("req_ready_at_accept", 32'(req_r[d]), 32'd1);
    step();
    acc = cyc;
    req_v[d] = 1'b0;
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall hold cycles, then handshake.
  task automatic wait_resp(input int d, input int acc, input int hold, input string tag);
    int   n = 0;
    exp_t e;
    while (!rsp_v[d] && n < 40) begin
      check({tag, "_busy_wait"}, 32'(bsy[d]), 32'd1);
      step();
      n++;
    end
    check({tag, "_resp_valid"}, 32'(rsp_v[d]), 32'd1);
    check({tag, "_latency"}, 32'(cyc - acc), 32'(lat[d]));
    if (sb.size() == 0) e = '0;
    else e = sb.pop_front();
    check({tag, "_rdata"}, rsp_d[d], e.rd);
    check({tag, "_err"}, 32'(rsp_e[d]), 32'(e.err));
    check({tag, "_busy_resp"}, 32'(bsy[d]), 32'd1);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_valid"}, 32'(rsp_v[d]), 32'd1);
      check({tag, "_hold_rdata"}, rsp_d[d], e.rd);
      check({tag, "_hold_ready"}, 32'(req_r[d]), 32'd0);
    end
    rsp_r[d] = 1'b1;
    step();
    check({tag, "_valid_drop"}, 32'(rsp_v[d]), 32'd0);
    check({tag, "_busy_drop"}, 32'(bsy[d]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int acc, prev, hs;
    rst   = 3'b111;
    req_v = 3'b000;
    req_w = 3'b000;
    rsp_r = 3'b111;
    for (int i = 0; i < 3; i++) begin
      req_a[i] = 32'd0;
      req_d[i] = 32'd0;
    end
    repeat (2) step();
    for (int d = 0; d < 3; d++) begin
      check("rst_req_ready", 32'(req_r[d]), 32'd0);
      check("rst_resp_valid", 32'(rsp_v[d]), 32'd0);
      check("rst_busy", 32'(bsy[d]), 32'd0);
      check("rst_rdata", rsp_d[d], 32'd0);
      check("rst_err", 32'(rsp_e[d]), 32'd0);
    end
    rst = 3'b000;
    #1;
    check("post_rst_req_ready", 32'(req_r[0]), 32'd1);

    // Basic store/load, misaligned store, out-of-range load (LATENCY 2)
    push(32'd0, 1'b0);
    send(0, 1'b1, 32'h10, 32'hDEADBEEF, acc);
    wait_resp(0, acc, 0, "st10");
    push(32'hDEADBEEF, 1'b0);
    send(0, 1'b0, 32'h10, 32'd0, acc);
    wait_resp(0, acc, 0, "ld10");
    push(32'd0, 1'b1);
    send(0, 1'b1, 32'h13, 32'h1234, acc);
    wait_resp(0, acc, 0, "st13_mis");
    push(32'hDEADBEEF, 1'b0);
    send(0, 1'b0, 32'h10, 32'd0, acc);
    wait_resp(0, acc, 0, "ld10_after_mis");
    push(32'd0, 1'b1);
    send(0, 1'b0, 32'h400, 32'd0, acc);
    wait_resp(0, acc, 0, "ld400_range");

    // Backpressure with a competing store held on the request port
    rsp_r[0] = 1'b0;
    push(32'hDEADBEEF, 1'b0);
    send(0, 1'b0, 32'h10, 32'd0, acc);
    req_v[0] = 1'b1;
    req_w[0] = 1'b1;
    req_a[0] = 32'h14;
    req_d[0] = 32'h11111111;
    wait_resp(0, acc, 5, "bp_ld10");
    hs = cyc;
    push(32'd0, 1'b0);
    send(0, 1'b1, 32'h14, 32'h11111111, acc);
    check("bp_second_accept_cycle", 32'(acc - hs), 32'd1);
    wait_resp(0, acc, 0, "bp_st14");
    push(32'h11111111, 1'b0);
    send(0, 1'b0, 32'h14, 32'd0, acc);
    wait_resp(0, acc, 0, "ld14");

    // Reset during WAIT discards an uncommitted store (LATENCY 4)
    push(32'd0, 1'b0);
    send(1, 1'b1, 32'h20, 32'd0, acc);
    wait_resp(1, acc, 0, "pre20");
    send(1, 1'b1, 32'h20, 32'hA5A5A5A5, acc);
    step();
    step();
    rst[1] = 1'b1;
    #1;
    check("midrst_req_ready", 32'(req_r[1]), 32'd0);
    check("midrst_resp_valid", 32'(rsp_v[1]), 32'd0);
    check("midrst_busy", 32'(bsy[1]), 32'd0);
    check("midrst_rdata", rsp_d[1], 32'd0);
    check("midrst_err", 32'(rsp_e[1]), 32'd0);
    repeat (3) step();
    rst[1] = 1'b0;
    #1;
    check("midrst_release_ready", 32'(req_r[1]), 32'd1);
    push(32'd0, 1'b0);
    send(1, 1'b0, 32'h20, 32'd0, acc);
    wait_resp(1, acc, 0, "ld20_after_rst");

    // LATENCY 1 back-to-back loads
    for (int i = 0; i < 4; i++) begin
      push(32'd0, 1'b0);
      send(2, 1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i), acc);
      wait_resp(2, acc, 0, "b2b_st");
    end
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      push(32'hC0DE0000 + 32'(i), 1'b0);
      send(2, 1'b0, 32'(i * 4), 32'd0, acc);
      wait_resp(2, acc, 0, "b2b_ld");
      if (i > 0) check("b2b_spacing", 32'(acc - prev), 32'd3);
      prev = acc;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
